letter_tx_fifo: RTL and testbench



---
 rtl/letter_tx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_letter_tx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/letter_tx_fifo.sv
// rtl/letter_tx_fifo.sv - ordered letter queue feeding the IR transmitter with a valid/busy handshake
module letter_tx_fifo #(
  parameter int DATA_WIDTH   = 5,
  parameter int DEPTH        = 1000,
  parameter bit OVERWRITE    = 1'b0,
  parameter bit WR_EDGE      = 1'b1,
  parameter int RETRY_CYCLES = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       wr_valid_in,
  input  logic [DATA_WIDTH-1:0]      wr_data_in,
  input  logic                       flush_in,
  input  logic                       tx_busy_in,
  output logic                       tx_valid_out,
  output logic [DATA_WIDTH-1:0]      tx_data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       empty_out,
  output logic                       full_out,
  output logic                       overflow_out,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_out,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  fetch_cnt;
  logic [RW-1:0]         retry_cnt;
  logic                  wr_valid_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q1;
  logic [DATA_WIDTH-1:0] rd_q2;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;

  logic wr_strobe;
  logic wr_req;
  logic pop;
  logic full;
  logic room;
  logic wr_store;
  logic wr_ovw;
  logic wr_drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle frees an entry, so a write to a full queue that
  // coincides with a pop is stored normally. Overwriting the oldest entry is
  // only safe while nothing is in flight, i.e. in IDLE.
  assign wr_strobe = WR_EDGE ? (wr_valid_in & ~wr_valid_q) : wr_valid_in;
  assign wr_req    = wr_strobe & ~flush_in;
  assign pop       = (state == S_WAIT_DONE) & ~tx_busy_in & ~flush_in;
  assign full      = (count == CW'(DEPTH));
  assign room      = ~full | pop;
  assign wr_store  = wr_req & room;
  assign wr_ovw    = wr_req & ~room & OVERWRITE & (state == S_IDLE);
  assign wr_drop   = wr_req & ~room & ~wr_ovw;

  // Previous write strobe for rising-edge qualification
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_valid_q <= 1'b0;
    end else begin
      wr_valid_q <= wr_valid_in;
    end
  end

  // Letter RAM with a two-stage registered read of the head slot
  always_ff @(posedge clk_in) begin
    if (wr_store || wr_ovw) begin
      mem[wr_ptr] <= wr_data_in;
    end
    rd_q1 <= mem[rd_ptr];
    rd_q2 <= rd_q1;
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_store || wr_ovw) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop || wr_ovw) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_drop || wr_ovw) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmit FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Transmit FSM next state; leaving IDLE is held off for one cycle when an
  // overwrite moves the head, so the read pipeline sees the new head
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if ((count != '0) && !tx_busy_in && !wr_ovw) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_cnt) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy_in) begin
          state_nxt = S_WAIT_DONE;
        end else if (retry_cnt == RW'(RETRY_CYCLES - 1)) begin
          state_nxt = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_in) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (flush_in) begin
      state_nxt = S_IDLE;
    end
  end

  // FETCH and WAIT_BUSY dwell counters, cleared whenever their state is left
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_cnt <= 1'b0;
      retry_cnt <= '0;
    end else begin
      fetch_cnt <= (state == S_FETCH) && !fetch_cnt;
      if (state == S_WAIT_BUSY) begin
        retry_cnt <= retry_cnt + RW'(1);
      end else begin
        retry_cnt <= '0;
      end
    end
  end

  // Head letter captured at the end of FETCH and held until the next fetch
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_data <= '0;
    end else if ((state == S_FETCH) && fetch_cnt && !flush_in) begin
      tx_data <= rd_q2;
    end
  end

  assign tx_valid_out = (state == S_ISSUE);
  assign tx_data_out  = tx_data;
  assign count_out    = count;
  assign empty_out    = (count == '0);
  assign full_out     = full;
  assign overflow_out = overflow;
  assign wr_ptr_out   = wr_ptr;
  assign rd_ptr_out   = rd_ptr;

endmodule

// File: tb/tb_letter_tx_fifo.sv
// tb/tb_letter_tx_fifo.sv - scoreboard bench for letter_tx_fifo
module tb_letter_tx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: DEPTH 4 drop, 1: DEPTH 4 overwrite, 2: DEPTH 8 level write, 3: DEPTH 3
  logic       wr_valid   [4];
  logic [4:0] wr_data    [4];
  logic       flush      [4];
  logic       force_busy [4];
  logic       model_en   [4];
  logic       mbusy      [4] = '{default: 1'b0};
  logic       pend       [4] = '{default: 1'b0};
  int         hold       [4] = '{default: 0};
  logic       busy       [4];
  logic       txv        [4];
  logic [4:0] txd        [4];
  logic       empty      [4];
  logic       full       [4];
  logic       ovf        [4];
  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic [1:0] cnt_d;
  logic [1:0] wp_a, rp_a, wp_b, rp_b, wp_d, rp_d;
  logic [2:0] wp_c, rp_c;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [1:0] inst;
    logic [4:0] data;
  } exp_t;
  exp_t sb[$];

  for (genvar g = 0; g < 4; g++) begin : g_busy
    assign busy[g] = force_busy[g] | mbusy[g];
  end

  letter_tx_fifo #(.DATA_WIDTH(5), .DEPTH(4), .OVERWRITE(1'b0), .WR_EDGE(1'b1), .RETRY_CYCLES(16)) u_drop (
    .clk_in(clk), .rst_n_in(rst_n), .wr_valid_in(wr_valid[0]), .wr_data_in(wr_data[0]),
    .flush_in(flush[0]), .tx_busy_in(busy[0]), .tx_valid_out(txv[0]), .tx_data_out(txd[0]),
    .count_out(cnt_a), .empty_out(empty[0]), .full_out(full[0]), .overflow_out(ovf[0]),
    .wr_ptr_out(wp_a), .rd_ptr_out(rp_a));

  letter_tx_fifo #(.DATA_WIDTH(5), .DEPTH(4), .OVERWRITE(1'b1), .WR_EDGE(1'b1), .RETRY_CYCLES(16)) u_ovw (
    .clk_in(clk), .rst_n_in(rst_n), .wr_valid_in(wr_valid[1]), .wr_data_in(wr_data[1]),
    .flush_in(flush[1]), .tx_busy_in(busy[1]), .tx_valid_out(txv[1]), .tx_data_out(txd[1]),
    .count_out(cnt_b), .empty_out(empty[1]), .full_out(full[1]), .overflow_out(ovf[1]),
    .wr_ptr_out(wp_b), .rd_ptr_out(rp_b));

  letter_tx_fifo #(.DATA_WIDTH(5), .DEPTH(8), .OVERWRITE(1'b0), .WR_EDGE(1'b0), .RETRY_CYCLES(16)) u_lvl (
    .clk_in(clk), .rst_n_in(rst_n), .wr_valid_in(wr_valid[2]), .wr_data_in(wr_data[2]),
    .flush_in(flush[2]), .tx_busy_in(busy[2]), .tx_valid_out(txv[2]), .tx_data_out(txd[2]),
    .count_out(cnt_c), .empty_out(empty[2]), .full_out(full[2]), .overflow_out(ovf[2]),
    .wr_ptr_out(wp_c), .rd_ptr_out(rp_c));

  letter_tx_fifo #(.DATA_WIDTH(5), .DEPTH(3), .OVERWRITE(1'b0), .WR_EDGE(1'b1), .RETRY_CYCLES(16)) u_wrap (
    .clk_in(clk), .rst_n_in(rst_n), .wr_valid_in(wr_valid[3]), .wr_data_in(wr_data[3]),
    .flush_in(flush[3]), .tx_busy_in(busy[3]), .tx_valid_out(txv[3]), .tx_data_out(txd[3]),
    .count_out(cnt_d), .empty_out(empty[3]), .full_out(full[3]), .overflow_out(ovf[3]),
    .wr_ptr_out(wp_d), .rd_ptr_out(rp_d));

  function automatic int cnt(input int i);
    case (i)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      2:       return int'(cnt_c);
      default: return int'(cnt_d);
    endcase
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [4:0] d);
    exp_t e;
    e.inst = 2'(i);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int i);
    int idx = -1;
    for (int k = 0; k < sb.size(); k++) begin
      if (idx < 0 && sb[k].inst == 2'(i)) idx = k;
    end
    check_eq($sformatf("sb_hit%0d", i), (idx >= 0) ? 1 : 0, 1);
    if (idx >= 0) begin
      check_eq($sformatf("tx_data%0d", i), int'(txd[i]), int'(sb[idx].data));
      sb.delete(idx);
    end
  endtask

  task automatic sb_drop(input int i);
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].inst == 2'(i)) sb.delete(k);
    end
  endtask

  task automatic wr(input int i, input logic [4:0] d);
    @(negedge clk);
    wr_valid[i] = 1'b1;
    wr_data[i]  = d;
    @(negedge clk);
    wr_valid[i] = 1'b0;
  endtask

  // kind 0: valid pulse, 1: busy high, 2: busy low, 3: queue empty
  task automatic wait_cond(input int i, input int kind, input int budget, input string tag);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      case (kind)
        0:       seen = txv[i];
        1:       seen = busy[i];
        2:       seen = !busy[i];
        default: seen = (cnt(i) == 0);
      endcase
    end
    check_eq(tag, int'(seen), 1);
  endtask

  // Transmitter model: busy rises one cycle after a pulse and holds 20 cycles
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (hold[i] > 0) begin
        hold[i]--;
        if (hold[i] == 0) mbusy[i] = 1'b0;
      end
      if (pend[i]) begin
        pend[i]  = 1'b0;
        mbusy[i] = 1'b1;
        hold[i]  = 20;
      end
      if (model_en[i] && txv[i]) begin
        pend[i] = 1'b1;
        sb_pop(i);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    for (int i = 0; i < 4; i++) begin
      wr_valid[i] = 1'b0; wr_data[i] = '0; flush[i] = 1'b0;
      force_busy[i] = 1'b0; model_en[i] = 1'b0;
    end
    force_busy[2] = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_count", int'(cnt_a), 0);
    check_eq("rst_empty", int'(empty[0]), 1);
    check_eq("rst_valid", int'(txv[0]), 0);
    check_eq("rst_full", int'(full[0]), 0);
    check_eq("rst_ovf", int'(ovf[0]), 0);
    check_eq("rst_ptrs", int'({wp_a, rp_a}), 0);
    rst_n = 1'b1;
    model_en[0] = 1'b1;
    model_en[3] = 1'b1;
    @(negedge clk);

    // single letter latency
    push_exp(0, 5'd7);
    wr(0, 5'd7);
    check_eq("single_count", int'(cnt_a), 1);
    @(negedge clk); check_eq("lat_n1", int'(txv[0]), 0);
    @(negedge clk); check_eq("lat_n2", int'(txv[0]), 0);
    @(negedge clk); check_eq("lat_n3", int'(txv[0]), 1);
    wait_cond(0, 3, 100, "single_drain");

    // full with drop policy
    force_busy[0] = 1'b1;
    @(negedge clk);
    for (int d = 1; d <= 5; d++) wr(0, 5'(d));
    check_eq("drop_count", int'(cnt_a), 4);
    check_eq("drop_full", int'(full[0]), 1);
    check_eq("drop_ovf", int'(ovf[0]), 1);
    for (int d = 1; d <= 4; d++) push_exp(0, 5'(d));
    force_busy[0] = 1'b0;
    wait_cond(0, 3, 400, "drop_drain");
    check_eq("drop_ovf_sticky", int'(ovf[0]), 1);

    // busy never rises: re-pulse after RETRY_CYCLES
    model_en[0] = 1'b0;
    wr(0, 5'd9);
    wait_cond(0, 0, 10, "retry_first");
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (n == 5) begin
        push_exp(0, 5'd9);
        model_en[0] = 1'b1;
      end
      seen = txv[0];
      if (!seen) n++;
    end
    check_eq("retry_gap", n, 16);
    wait_cond(0, 3, 200, "retry_drain");

    // flush while waiting for busy to fall
    push_exp(0, 5'd11);
    wr(0, 5'd11); wr(0, 5'd12); wr(0, 5'd13);
    wait_cond(0, 1, 40, "flush_busy");
    repeat (2) @(negedge clk);
    check_eq("pre_flush_count", int'(cnt_a), 3);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    check_eq("flush_count", int'(cnt_a), 0);
    check_eq("flush_empty", int'(empty[0]), 1);
    check_eq("flush_ovf", int'(ovf[0]), 0);
    check_eq("flush_ptrs", int'({wp_a, rp_a}), 0);
    wait_cond(0, 2, 40, "flush_busy_fall");
    repeat (3) @(negedge clk);
    check_eq("flush_nopop_count", int'(cnt_a), 0);
    check_eq("flush_nopop_rd", int'(rp_a), 0);

    // write qualification: held strobe, edge vs level
    force_busy[0] = 1'b1;
    @(negedge clk);
    wr_valid[0] = 1'b1; wr_data[0] = 5'd20;
    wr_valid[2] = 1'b1; wr_data[2] = 5'd20;
    repeat (5) @(negedge clk);
    wr_valid[0] = 1'b0;
    wr_valid[2] = 1'b0;
    @(negedge clk);
    check_eq("edge_count", int'(cnt_a), 1);
    check_eq("level_count", int'(cnt_c), 5);

    // full with overwrite policy
    force_busy[1] = 1'b1;
    @(negedge clk);
    for (int d = 1; d <= 6; d++) wr(1, 5'(d));
    check_eq("ovw_count", int'(cnt_b), 4);
    check_eq("ovw_full", int'(full[1]), 1);
    check_eq("ovw_ovf", int'(ovf[1]), 1);
    for (int d = 3; d <= 6; d++) push_exp(1, 5'(d));
    model_en[1] = 1'b1;
    force_busy[1] = 1'b0;
    wait_cond(1, 1, 40, "ovw_busy");
    repeat (2) @(negedge clk);
    wr(1, 5'd7);
    check_eq("ovw_inflight_count", int'(cnt_b), 4);
    check_eq("ovw_head", int'(txd[1]), 3);
    wait_cond(1, 3, 400, "ovw_drain");

    // DEPTH 3 wrap: head pointer sequence
    for (int k = 0; k < 7; k++) begin
      push_exp(3, 5'(k + 1));
      wr(3, 5'(k + 1));
      wait_cond(3, 0, 10, "wrap_issue");
      check_eq($sformatf("wrap_rd_ptr%0d", k), int'(rp_d), k % 3);
      wait_cond(3, 3, 100, "wrap_drain");
    end

    // write coinciding with a pop on a full queue
    for (int d = 10; d <= 12; d++) push_exp(3, 5'(d));
    wr(3, 5'd10); wr(3, 5'd11); wr(3, 5'd12);
    check_eq("simul_pre_count", int'(cnt_d), 3);
    check_eq("simul_pre_full", int'(full[3]), 1);
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      #1;
      seen = !busy[3];
      n++;
    end
    check_eq("simul_busy_fall", int'(seen), 1);
    wr_valid[3] = 1'b1; wr_data[3] = 5'd13;
    push_exp(3, 5'd13);
    @(negedge clk);
    wr_valid[3] = 1'b0;
    check_eq("simul_count", int'(cnt_d), 3);
    check_eq("simul_no_ovf", int'(ovf[3]), 0);
    wait_cond(3, 3, 300, "simul_drain");

    // asynchronous reset in WAIT_DONE
    wr(0, 5'd21); wr(0, 5'd22);
    push_exp(0, 5'd20);
    force_busy[0] = 1'b0;
    wait_cond(0, 1, 40, "rst_busy");
    repeat (2) @(negedge clk);
    check_eq("rst_pre_count", int'(cnt_a), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_count", int'(cnt_a), 0);
    check_eq("arst_empty", int'(empty[0]), 1);
    check_eq("arst_valid", int'(txv[0]), 0);
    repeat (25) @(negedge clk);
    rst_n = 1'b1;
    sb_drop(0);
    push_exp(0, 5'd30);
    wr(0, 5'd30);
    @(negedge clk); check_eq("post_rst_n1", int'(txv[0]), 0);
    @(negedge clk); check_eq("post_rst_n2", int'(txv[0]), 0);
    @(negedge clk); check_eq("post_rst_n3", int'(txv[0]), 1);
    wait_cond(0, 3, 100, "post_rst_drain");

    repeat (5) @(negedge clk);
    check_eq("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
